audio_sample_scheduler: RTL and testbench
=========================================

// Module: audio_sample_scheduler
// PURPOSE
//  Paces the audio output datapath: divides sys_clock into a sample-rate tick and, once per tick,
//  moves one stereo sample from one of two sources (tone generator, playback stream) into the
//  audio FIFO that feeds the left/right delta-sigma modulators. Round-robin between sources,
//  inserts silence on underrun, back-pressures on audio_fifo_full, gated by PLL lock.
// PARAMETERS
//  DATA_W   16    bits per channel sample
//  DIV      1024  sys_clock cycles per sample slot (50 MHz / 1024 = 48.8 kHz); must be >= 4
// PORTS
//  sys_clock       in   1         system clock, all logic on rising edge
//  reset_          in   1         asynchronous, active-low reset
//  pll_locked      in   1         audio PLL lock; scheduler runs only while high
//  enable          in   1         software run enable
//  src0_valid      in   1         source 0 has a sample
//  src0_data       in   2*DATA_W  {left,right} sample, source 0
//  src0_ready      out  1         1-cycle pulse: src0 sample consumed
//  src1_valid      in   1         source 1 has a sample
//  src1_data       in   2*DATA_W  {left,right} sample, source 1
//  src1_ready      out  1         1-cycle pulse: src1 sample consumed
//  audio_fifo_full in   1         FIFO cannot accept a write this cycle
//  fifo_wr         out  1         1-cycle write strobe
//  fifo_data       out  2*DATA_W  sample written with fifo_wr
//  grant_src       out  1         source index of last real (non-silence) write
//  underrun        out  1         1-cycle pulse: silence inserted
//  slot_drop       out  1         1-cycle pulse: tick arrived with a slot still pending
// BEHAVIOUR
//  - Reset: all outputs 0, divider 0, state IDLE, rr pointer = src0, pending = 0.
//  - run = pll_locked & enable. run low in any state -> next cycle IDLE, divider 0, pending
//    cleared, no fifo_wr/ready issued; an in-flight write is abandoned, never half-done.
//  - Divider counts 0..DIV-1 while run; tick = (count == DIV-1), wraps to 0. First tick DIV
//    cycles after run rises.
//  - States: IDLE -> WAIT (run high). WAIT -> ARB on tick (pending=1).
//    ARB: audio_fifo_full -> STALL; else write this cycle, -> WAIT.
//    STALL: stays while audio_fifo_full; else -> ARB. Divider keeps running in STALL.
//  - Latency: tick in cycle T, FIFO not full, source valid -> fifo_wr & srcN_ready in T+1.
//  - Arbitration (in ARB, not full): both valid -> grant source != last granted; one valid ->
//    grant it; none -> fifo_data = 0, fifo_wr = 1, underrun = 1, rr pointer unchanged.
//  - Handshake: srcN_ready asserted only in the same cycle as fifo_wr carrying srcN_data;
//    sources hold valid/data until ready. fifo_wr never asserted while audio_fifo_full high.
//  - Only one slot pending: tick while in ARB/STALL -> slot_drop pulse in the tick cycle,
//    pending slot kept, new slot discarded (never two writes per slot).
//  - fifo_data/grant_src hold their last value between writes (fifo_data zeroed on silence).
// CONFIGURATION
//  AUDIO_SCHED_STATS_EN defined: adds outputs underrun_count[15:0], drop_count[15:0];
//   increment on underrun / slot_drop, saturate at 16'hFFFF, cleared only by reset_.
//  Undefined: ports absent, no counters; all other behaviour identical.
// TESTING
//  1 Reset: reset_=0 mid-STALL -> all outputs 0 immediately; after release first tick at DIV cycles.
//  2 src0 only valid, data 32'h1234_ABCD, FIFO empty -> fifo_wr+src0_ready 1 cycle after each
//    tick, fifo_data = 32'h1234_ABCD, grant_src = 0, underrun never.
//  3 Both valid continuously, 6 ticks -> grant_src sequence 1,0,1,0,1,0 (rr starts at src0 last).
//  4 No source valid -> per tick fifo_wr=1, fifo_data=0, underrun=1; with STATS_EN count = ticks.
//  5 audio_fifo_full held 1.5*DIV cycles across a tick -> no fifo_wr while full, slot_drop pulses
//    once at next tick, exactly one write the cycle after full falls.
//  6 pll_locked dropped during STALL -> IDLE, no write; relock -> first write DIV+1 cycles later.

Source files
------------

// File: rtl/audio_sample_scheduler_if.sv
// ============================================================================
// Module      : audio_sample_scheduler_if
// Description : Bundles the scheduler's control, source and FIFO signals.
//               The optional statistics outputs exist only when
//               AUDIO_SCHED_STATS_EN is defined.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

interface audio_sample_scheduler_if #(
  parameter int DATA_W = 16
);
  logic                  i_pll_locked;
  logic                  i_enable;
  logic                  i_src0_valid;
  logic [2*DATA_W-1:0]   i_src0_data;
  logic                  o_src0_ready;
  logic                  i_src1_valid;
  logic [2*DATA_W-1:0]   i_src1_data;
  logic                  o_src1_ready;
  logic                  i_audio_fifo_full;
  logic                  o_fifo_wr;
  logic [2*DATA_W-1:0]   o_fifo_data;
  logic                  o_grant_src;
  logic                  o_underrun;
  logic                  o_slot_drop;
`ifdef AUDIO_SCHED_STATS_EN
  logic [15:0]           o_underrun_count;
  logic [15:0]           o_drop_count;
`endif

  modport master (
    output i_pll_locked, i_enable,
    output i_src0_valid, i_src0_data, input o_src0_ready,
    output i_src1_valid, i_src1_data, input o_src1_ready,
    output i_audio_fifo_full,
    input  o_fifo_wr, o_fifo_data, o_grant_src, o_underrun, o_slot_drop
`ifdef AUDIO_SCHED_STATS_EN
    , input o_underrun_count, o_drop_count
`endif
  );

  modport slave (
    input  i_pll_locked, i_enable,
    input  i_src0_valid, i_src0_data, output o_src0_ready,
    input  i_src1_valid, i_src1_data, output o_src1_ready,
    input  i_audio_fifo_full,
    output o_fifo_wr, o_fifo_data, o_grant_src, o_underrun, o_slot_drop
`ifdef AUDIO_SCHED_STATS_EN
    , output o_underrun_count, o_drop_count
`endif
  );
endinterface

`default_nettype wire

// File: rtl/audio_sample_scheduler.sv
// ============================================================================
// Module      : audio_sample_scheduler
// Description : Sample-rate tick generator and round-robin source scheduler
//               feeding the audio FIFO. Define AUDIO_SCHED_STATS_EN to add
//               saturating underrun/drop counters.
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module audio_sample_scheduler #(
  parameter int DATA_W = 16,
  parameter int DIV    = 1024
) (
  input  wire                    i_sys_clock,
  input  wire                    i_reset_,
  audio_sample_scheduler_if.slave bus
);
  localparam int              CNT_W      = $clog2(DIV);
  localparam logic [CNT_W-1:0] c_DIV_LAST = CNT_W'(DIV - 1);

  typedef enum logic [1:0] {
    S_IDLE  = 2'd0,
    S_WAIT  = 2'd1,
    S_ARB   = 2'd2,
    S_STALL = 2'd3
  } state_t;

  state_t              r_state;
  state_t              w_state_nx;
  logic [CNT_W-1:0]    r_div;
  logic [2*DATA_W-1:0] r_fifo_data;
  logic                r_grant;

  logic                w_run;
  logic                w_tick;
  logic                w_pick1;
  logic                w_wr;
  logic [2*DATA_W-1:0] w_wdata;
  logic                w_rdy0;
  logic                w_rdy1;
  logic                w_underrun;
  logic                w_drop;
  logic                w_real;
  logic                w_gnt;

  assign w_run   = bus.i_pll_locked & bus.i_enable;
  // The divider is held at zero in IDLE so the first tick lands DIV cycles after run rises.
  assign w_tick  = w_run && (r_state != S_IDLE) && (r_div == c_DIV_LAST);
  assign w_pick1 = bus.i_src1_valid && (!bus.i_src0_valid || !r_grant);

  always_ff @(posedge i_sys_clock or negedge i_reset_) begin
    if (!i_reset_) begin
      r_state     <= S_IDLE;
      r_div       <= '0;
      r_fifo_data <= '0;
      r_grant     <= 1'b0;
    end else begin
      r_state <= w_state_nx;
      if (!w_run || r_state == S_IDLE || r_div == c_DIV_LAST)
        r_div <= '0;
      else
        r_div <= r_div + 1'b1;
      if (w_wr)
        r_fifo_data <= w_wdata;
      if (w_real)
        r_grant <= w_gnt;
    end
  end

  always_comb begin
    w_state_nx = r_state;
    w_wr       = 1'b0;
    w_wdata    = '0;
    w_rdy0     = 1'b0;
    w_rdy1     = 1'b0;
    w_underrun = 1'b0;
    w_drop     = 1'b0;
    w_real     = 1'b0;
    w_gnt      = r_grant;
    if (!w_run) begin
      w_state_nx = S_IDLE;
    end else begin
      case (r_state)
        S_IDLE: w_state_nx = S_WAIT;
        S_WAIT: if (w_tick) w_state_nx = S_ARB;
        S_ARB: begin
          w_drop = w_tick;
          if (bus.i_audio_fifo_full) begin
            w_state_nx = S_STALL;
          end else begin
            w_state_nx = S_WAIT;
            w_wr       = 1'b1;
            if (w_pick1) begin
              w_wdata = bus.i_src1_data;
              w_rdy1  = 1'b1;
              w_real  = 1'b1;
              w_gnt   = 1'b1;
            end else if (bus.i_src0_valid) begin
              w_wdata = bus.i_src0_data;
              w_rdy0  = 1'b1;
              w_real  = 1'b1;
              w_gnt   = 1'b0;
            end else begin
              w_underrun = 1'b1;
            end
          end
        end
        S_STALL: begin
          w_drop = w_tick;
          if (!bus.i_audio_fifo_full) w_state_nx = S_ARB;
        end
        default: w_state_nx = S_IDLE;
      endcase
    end
  end

  // Data and grant show the new value in the write cycle and hold it afterwards.
  assign bus.o_fifo_wr    = w_wr;
  assign bus.o_fifo_data  = w_wr ? w_wdata : r_fifo_data;
  assign bus.o_grant_src  = w_real ? w_gnt : r_grant;
  assign bus.o_src0_ready = w_rdy0;
  assign bus.o_src1_ready = w_rdy1;
  assign bus.o_underrun   = w_underrun;
  assign bus.o_slot_drop  = w_drop;

`ifdef AUDIO_SCHED_STATS_EN
  logic [15:0] r_underrun_cnt;
  logic [15:0] r_drop_cnt;

  always_ff @(posedge i_sys_clock or negedge i_reset_) begin
    if (!i_reset_) begin
      r_underrun_cnt <= '0;
      r_drop_cnt     <= '0;
    end else begin
      if (w_underrun && r_underrun_cnt != 16'hFFFF)
        r_underrun_cnt <= r_underrun_cnt + 16'd1;
      if (w_drop && r_drop_cnt != 16'hFFFF)
        r_drop_cnt <= r_drop_cnt + 16'd1;
    end
  end

  assign bus.o_underrun_count = r_underrun_cnt;
  assign bus.o_drop_count     = r_drop_cnt;
`endif

endmodule

`default_nettype wire

// File: tb/tb_audio_sample_scheduler.sv
// ============================================================================
// Module      : tb_audio_sample_scheduler
// Description : Directed self-checking bench for audio_sample_scheduler
//               (honours AUDIO_SCHED_STATS_EN when defined).
// Revision    : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_audio_sample_scheduler;
  localparam int c_DW  = 16;
  localparam int c_DIV = 8;
  localparam logic [31:0] c_D0 = 32'h1234_ABCD;
  localparam logic [31:0] c_D1 = 32'h5555_AAAA;

  logic r_clk = 1'b0;
  logic r_rst_n = 1'b0;
  int   cyc = 0;
  int   n_chk = 0;
  int   n_bad = 0;

  audio_sample_scheduler_if #(.DATA_W(c_DW)) bus ();

  audio_sample_scheduler #(.DATA_W(c_DW), .DIV(c_DIV)) dut (
    .i_sys_clock (r_clk),
    .i_reset_    (r_rst_n),
    .bus         (bus)
  );

  always #5 r_clk = ~r_clk;
  always @(posedge r_clk) cyc <= cyc + 1;

  // Event log sampled mid-cycle.
  int          n_wr = 0, n_under = 0, n_drop = 0, n_rdy0 = 0, n_rdy1 = 0;
  int          wr_full_err = 0, hs_err = 0, last_drop_cyc = -1;
  int          wr_cyc  [0:255];
  logic [31:0] wr_data [0:255];
  logic        wr_grant[0:255];

  always @(negedge r_clk) begin
    if (bus.o_fifo_wr) begin
      if (n_wr < 256) begin
        wr_cyc[n_wr]   = cyc;
        wr_data[n_wr]  = bus.o_fifo_data;
        wr_grant[n_wr] = bus.o_grant_src;
      end
      n_wr++;
      if (bus.i_audio_fifo_full) wr_full_err++;
    end
    if (bus.o_underrun) n_under++;
    if (bus.o_slot_drop) begin
      n_drop++;
      last_drop_cyc = cyc;
    end
    if (bus.o_src0_ready) begin
      n_rdy0++;
      if (!(bus.o_fifo_wr && bus.o_fifo_data == bus.i_src0_data)) hs_err++;
    end
    if (bus.o_src1_ready) begin
      n_rdy1++;
      if (!(bus.o_fifo_wr && bus.o_fifo_data == bus.i_src1_data)) hs_err++;
    end
  end

  task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic wait_until(input int target);
    while (cyc < target) begin
      @(posedge r_clk);
      #1;
    end
  endtask

  task automatic check_outputs_zero(input string tag);
    check_val({tag, "_wr"},    64'(bus.o_fifo_wr),    64'd0);
    check_val({tag, "_data"},  64'(bus.o_fifo_data),  64'd0);
    check_val({tag, "_grant"}, 64'(bus.o_grant_src),  64'd0);
    check_val({tag, "_under"}, 64'(bus.o_underrun),   64'd0);
    check_val({tag, "_drop"},  64'(bus.o_slot_drop),  64'd0);
    check_val({tag, "_rdy"},   64'({bus.o_src0_ready, bus.o_src1_ready}), 64'd0);
`ifdef AUDIO_SCHED_STATS_EN
    check_val({tag, "_ucnt"},  64'(bus.o_underrun_count), 64'd0);
    check_val({tag, "_dcnt"},  64'(bus.o_drop_count),     64'd0);
`endif
  endtask

  initial begin
    #20000;
    $display("FAIL watchdog: got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int c0, c1, b, u0, r0, d, r;
    bus.i_pll_locked      = 1'b1;
    bus.i_enable          = 1'b1;
    bus.i_src0_valid      = 1'b0;
    bus.i_src0_data       = c_D0;
    bus.i_src1_valid      = 1'b0;
    bus.i_src1_data       = c_D1;
    bus.i_audio_fifo_full = 1'b0;

    // Reset state
    wait_until(3);
    check_outputs_zero("rst");

    // src0 only
    bus.i_src0_valid = 1'b1;
    wait_until(5);
    r_rst_n = 1'b1;
    c0 = cyc;
    wait_until(c0 + 3*c_DIV + 2);
    check_val("s0_nwr",   64'(n_wr), 64'd3);
    check_val("s0_first", 64'(wr_cyc[0]), 64'(c0 + c_DIV + 1));
    check_val("s0_third", 64'(wr_cyc[2]), 64'(c0 + 3*c_DIV + 1));
    check_val("s0_data",  64'(wr_data[2]), 64'(c_D0));
    check_val("s0_grant", 64'(wr_grant[2]), 64'd0);
    check_val("s0_rdy0",  64'(n_rdy0), 64'd3);
    check_val("s0_under", 64'(n_under), 64'd0);

    // Both valid: alternate starting at src1
    bus.i_src1_valid = 1'b1;
    b = n_wr;
    wait_until(c0 + 9*c_DIV + 2);
    check_val("rr_nwr", 64'(n_wr - b), 64'd6);
    check_val("rr_cyc", 64'(wr_cyc[b]), 64'(c0 + 4*c_DIV + 1));
    for (int i = 0; i < 6; i++)
      check_val($sformatf("rr_g%0d", i), 64'(wr_grant[b+i]), 64'((i % 2 == 0) ? 1 : 0));
    check_val("rr_d0", 64'(wr_data[b]),   64'(c_D1));
    check_val("rr_d1", 64'(wr_data[b+1]), 64'(c_D0));

    // No source: silence
    bus.i_src0_valid = 1'b0;
    bus.i_src1_valid = 1'b0;
    b  = n_wr;
    u0 = n_under;
    r0 = n_rdy0 + n_rdy1;
    wait_until(c0 + 12*c_DIV + 2);
    check_val("sil_nwr",   64'(n_wr - b), 64'd3);
    check_val("sil_under", 64'(n_under - u0), 64'd3);
    check_val("sil_data",  64'(wr_data[n_wr-1]), 64'd0);
    check_val("sil_rdy",   64'(n_rdy0 + n_rdy1 - r0), 64'd0);
    check_val("sil_ghold", 64'(bus.o_grant_src), 64'd0);
`ifdef AUDIO_SCHED_STATS_EN
    check_val("sil_ucnt",  64'(bus.o_underrun_count), 64'd3);
`endif

    // FIFO full for 1.5 slots across a tick
    bus.i_src0_valid = 1'b1;
    b = n_wr;
    wait_until(c0 + 13*c_DIV - 2);
    bus.i_audio_fifo_full = 1'b1;
    wait_until(c0 + 13*c_DIV + 10);
    bus.i_audio_fifo_full = 1'b0;
    wait_until(c0 + 13*c_DIV + 13);
    check_val("full_nwr",   64'(n_wr - b), 64'd1);
    check_val("full_wcyc",  64'(wr_cyc[b]), 64'(c0 + 13*c_DIV + 11));
    check_val("full_ndrop", 64'(n_drop), 64'd1);
    check_val("full_dcyc",  64'(last_drop_cyc), 64'(c0 + 14*c_DIV));
`ifdef AUDIO_SCHED_STATS_EN
    check_val("full_dcnt",  64'(bus.o_drop_count), 64'd1);
`endif

    // PLL loss during STALL, then relock
    wait_until(c0 + 15*c_DIV - 1);
    bus.i_audio_fifo_full = 1'b1;
    d = c0 + 15*c_DIV + 3;
    wait_until(d);
    b = n_wr;
    bus.i_pll_locked = 1'b0;
    wait_until(d + 2);
    bus.i_audio_fifo_full = 1'b0;
    wait_until(d + 3);
    bus.i_pll_locked = 1'b1;
    r = cyc;
    wait_until(r + c_DIV + 2);
    check_val("pll_nwr",  64'(n_wr - b), 64'd1);
    check_val("pll_wcyc", 64'(wr_cyc[b]), 64'(r + c_DIV + 1));

    // Reset asserted mid-STALL
    wait_until(r + 2*c_DIV - 1);
    bus.i_audio_fifo_full = 1'b1;
    wait_until(r + 2*c_DIV + 3);
    r_rst_n = 1'b0;
    #1;
    check_outputs_zero("rst2");
    bus.i_audio_fifo_full = 1'b0;
    wait_until(cyc + 2);
    b = n_wr;
    r_rst_n = 1'b1;
    c1 = cyc;
    wait_until(c1 + c_DIV + 2);
    check_val("rst2_nwr",  64'(n_wr - b), 64'd1);
    check_val("rst2_wcyc", 64'(wr_cyc[b]), 64'(c1 + c_DIV + 1));

    check_val("wr_while_full", 64'(wr_full_err), 64'd0);
    check_val("handshake",     64'(hs_err), 64'd0);

    $display("test done: total=%0d bad=%0d", n_chk, n_bad);
    $finish;
  end
endmodule

`default_nettype wire
